// File: rtl/game_sequencer_if.sv
// Button/collision inputs and play-state outputs of the dinosaur game sequencer.
interface game_sequencer_if;
    logic        up;
    logic        collision;
    logic [1:0]  state;
    logic        move_tick;
    logic        spawn;
    logic        jump_start;
    logic        airborne;
    logic [15:0] score;
    logic [2:0]  speed_level;

    modport master (
        output up, collision,
        input  state, move_tick, spawn, jump_start, airborne, score, speed_level
    );

    modport slave (
        input  up, collision,
        output state, move_tick, spawn, jump_start, airborne, score, speed_level
    );
endinterface

// File: rtl/game_sequencer.sv
// Play controller for the dinosaur game: game state sequencing, move tick,
// obstacle spawn scheduling, jump arbitration, BCD score and speed level.
//
// state | meaning
// INI   | idle; last score still shown, up_rise starts a new game
// RUN   | move ticks, spawns, jumps and scoring active
// DONE  | collision seen; score frozen, up_rise returns to INI
module game_sequencer #(
    parameter int unsigned BASE_DIV    = 2000000,
    parameter int unsigned DIV_STEP    = 200000,
    parameter int unsigned MIN_DIV     = 600000,
    parameter int unsigned SCORE_TICKS = 6,
    parameter int unsigned MIN_GAP     = 40,
    parameter int unsigned JUMP_TICKS  = 30,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input logic             clk,
    input logic             rst,
    game_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_INI     = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [23:0] BASE_W     = 24'(BASE_DIV);
    localparam logic [23:0] STEP_W     = 24'(DIV_STEP);
    localparam logic [23:0] MIN_W      = 24'(MIN_DIV);
    localparam logic [7:0]  GAP_MIN    = 8'(MIN_GAP);
    localparam logic [7:0]  JUMP_W     = 8'(JUMP_TICKS);
    localparam logic [7:0]  SCORE_LAST = 8'(SCORE_TICKS - 1);

    state_t      state_q, state_n;
    logic        up_d;
    logic        up_rise;
    logic        wrap;
    logic [23:0] tick_q, tick_n;
    logic [23:0] period_q, period_n;
    logic [7:0]  lfsr_q, lfsr_n;
    logic [7:0]  gap_q, gap_n;
    logic [7:0]  jump_q, jump_n;
    logic [7:0]  sub_q, sub_n;
    logic        air_q, air_n;
    logic [15:0] score_q, score_n;
    logic [2:0]  speed_q, speed_n;
    logic        move_q, move_n;
    logic        spawn_q, spawn_n;
    logic        jstart_q, jstart_n;

    // Saturating subtraction: the period never drops below MIN_DIV nor underflows.
    function automatic logic [23:0] period_for(input logic [2:0] lvl);
        logic [23:0] red;
        red = 24'(lvl) * STEP_W;
        if (red >= BASE_W || (BASE_W - red) < MIN_W) begin
            return MIN_W;
        end
        return BASE_W - red;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (s[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = s[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Galois form of x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    assign up_rise = bus.up & ~up_d;
    assign wrap    = (tick_q == period_q - 24'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INI;
            up_d     <= 1'b0;
            tick_q   <= 24'd0;
            period_q <= BASE_W;
            lfsr_q   <= LFSR_SEED;
            gap_q    <= GAP_MIN;
            jump_q   <= 8'd0;
            sub_q    <= 8'd0;
            air_q    <= 1'b0;
            score_q  <= 16'h0000;
            speed_q  <= 3'd0;
            move_q   <= 1'b0;
            spawn_q  <= 1'b0;
            jstart_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            up_d     <= bus.up;
            tick_q   <= tick_n;
            period_q <= period_n;
            lfsr_q   <= lfsr_n;
            gap_q    <= gap_n;
            jump_q   <= jump_n;
            sub_q    <= sub_n;
            air_q    <= air_n;
            score_q  <= score_n;
            speed_q  <= speed_n;
            move_q   <= move_n;
            spawn_q  <= spawn_n;
            jstart_q <= jstart_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        period_n = period_q;
        lfsr_n   = lfsr_q;
        gap_n    = gap_q;
        jump_n   = jump_q;
        sub_n    = sub_q;
        air_n    = air_q;
        score_n  = score_q;
        speed_n  = speed_q;
        move_n   = 1'b0;
        spawn_n  = 1'b0;
        jstart_n = 1'b0;
        case (state_q)
            ST_INI: begin
                if (up_rise) begin
                    state_n  = ST_RUN;
                    tick_n   = 24'd0;
                    period_n = period_for(3'd0);
                    gap_n    = GAP_MIN;
                    jump_n   = 8'd0;
                    sub_n    = 8'd0;
                    air_n    = 1'b0;
                    score_n  = 16'h0000;
                    speed_n  = 3'd0;
                end
            end
            ST_RUN: begin
                // Collision wins over everything due this cycle, including up_rise.
                if (bus.collision) begin
                    state_n = ST_DONE;
                    air_n   = 1'b0;
                end else begin
                    if (wrap) begin
                        tick_n = 24'd0;
                        move_n = 1'b1;
                        lfsr_n = lfsr_step(lfsr_q);
                        if (gap_q == 8'd1) begin
                            spawn_n = 1'b1;
                            gap_n   = GAP_MIN + {3'b000, lfsr_q[4:0]};
                        end else begin
                            gap_n = gap_q - 8'd1;
                        end
                        if (air_q && jump_q != 8'd0) begin
                            jump_n = jump_q - 8'd1;
                            if (jump_q == 8'd1) begin
                                air_n = 1'b0;
                            end
                        end
                        if (sub_q == SCORE_LAST) begin
                            sub_n = 8'd0;
                            if (score_q != 16'h9999) begin
                                score_n = bcd_inc(score_q);
                                if (score_q[7:0] == 8'h99 && speed_q != 3'd7) begin
                                    speed_n = speed_q + 3'd1;
                                end
                            end
                        end else begin
                            sub_n = sub_q + 8'd1;
                        end
                        period_n = period_for(speed_n);
                    end else begin
                        tick_n = tick_q + 24'd1;
                    end
                    if (up_rise && !air_q) begin
                        jstart_n = 1'b1;
                        air_n    = 1'b1;
                        jump_n   = JUMP_W;
                    end
                end
            end
            ST_DONE: begin
                if (up_rise) begin
                    state_n = ST_INI;
                end
            end
            default: state_n = ST_INI;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.move_tick   = move_q;
    assign bus.spawn       = spawn_q;
    assign bus.jump_start  = jstart_q;
    assign bus.airborne    = air_q;
    assign bus.score       = score_q;
    assign bus.speed_level = speed_q;
endmodule
